// File: rtl/easyaxi_slv_wr_pkg.sv
// Shared widths, AXI encodings and write-responder FSM states for the EASYAXI write path.
// Parameter defaults and the response priority function are taken from here.
package easyaxi_slv_wr_pkg;

   localparam int AXI_ID_W   = 4;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_LEN_W  = 8;
   localparam int AXI_USER_W = 4;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DATA = 2'b01,
      ST_RESP = 2'b10
   } wr_state_t;

   // A decode error outranks any slave error.
   function automatic logic [1:0] wr_resp(input logic dec_err, input logic slv_err);
      if (dec_err)      return RESP_DECERR;
      else if (slv_err) return RESP_SLVERR;
      else              return RESP_OKAY;
   endfunction

endpackage

// File: rtl/easyaxi_slv_wr_mem.sv
// Byte-enabled word storage for the write responder: async clear, one write port,
// combinational read port used for readback.
module easyaxi_slv_wr_mem #(
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 16,
   localparam int STRB_W   = DATA_W / 8,
   localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [STRB_W-1:0] wr_strb,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < STRB_W; b++)
            if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/easyaxi_slv_wr.sv
// AXI4 write-channel responder: accepts one AW burst at a time, stores W beats into a
// byte-enabled array and returns a single B response.
module easyaxi_slv_wr
   import easyaxi_slv_wr_pkg::*;
#(
   parameter int ID_W      = AXI_ID_W,
   parameter int ADDR_W    = AXI_ADDR_W,
   parameter int DATA_W    = AXI_DATA_W,
   parameter int LEN_W     = AXI_LEN_W,
   parameter int USER_W    = AXI_USER_W,
   parameter int MEM_DEPTH = 16,
   localparam int STRB_W   = DATA_W / 8,
   localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              axi_slv_awvalid,
   output logic              axi_slv_awready,
   input  logic [ID_W-1:0]   axi_slv_awid,
   input  logic [ADDR_W-1:0] axi_slv_awaddr,
   input  logic [LEN_W-1:0]  axi_slv_awlen,
   input  logic [2:0]        axi_slv_awsize,
   input  logic [1:0]        axi_slv_awburst,
   input  logic [USER_W-1:0] axi_slv_awuser,
   input  logic              axi_slv_wvalid,
   output logic              axi_slv_wready,
   input  logic [DATA_W-1:0] axi_slv_wdata,
   input  logic [STRB_W-1:0] axi_slv_wstrb,
   input  logic              axi_slv_wlast,
   output logic              axi_slv_bvalid,
   input  logic              axi_slv_bready,
   output logic [ID_W-1:0]   axi_slv_bid,
   output logic [1:0]        axi_slv_bresp,
   output logic [USER_W-1:0] axi_slv_buser,
   input  logic [IDX_W-1:0]  dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   localparam int WS     = $clog2(STRB_W);
   localparam int WIDX_W = ADDR_W - WS;
   localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(MEM_DEPTH);

   wr_state_t         state;
   logic [WIDX_W-1:0] widx;
   logic [LEN_W-1:0]  beat;
   logic [LEN_W-1:0]  len;
   logic [1:0]        burst;
   logic              cfg_err;
   logic              dec_err;
   logic              lst_err;

   logic w_hs;
   logic last_beat;
   logic in_range;
   logic dec_nxt;
   logic lst_nxt;
   logic mem_we;

   // Reset is folded in so awready reads low for the whole reset window.
   assign axi_slv_awready = rst_n & enable & (state == ST_IDLE);
   assign axi_slv_wready  = (state == ST_DATA);

   assign w_hs      = axi_slv_wvalid & axi_slv_wready;
   assign last_beat = (beat == len);
   assign in_range  = (widx < DEPTH_LIM);
   assign dec_nxt   = dec_err | ~in_range;
   assign lst_nxt   = lst_err | (axi_slv_wlast != last_beat);
   assign mem_we    = w_hs & ~cfg_err & in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         widx           <= '0;
         beat           <= '0;
         len            <= '0;
         burst          <= BURST_FIXED;
         cfg_err        <= 1'b0;
         dec_err        <= 1'b0;
         lst_err        <= 1'b0;
         axi_slv_bvalid <= 1'b0;
         axi_slv_bid    <= '0;
         axi_slv_bresp  <= RESP_OKAY;
         axi_slv_buser  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (axi_slv_awvalid && axi_slv_awready) begin
                  axi_slv_bid   <= axi_slv_awid;
                  axi_slv_buser <= axi_slv_awuser;
                  len           <= axi_slv_awlen;
                  burst         <= axi_slv_awburst;
                  widx          <= WIDX_W'(axi_slv_awaddr >> WS);
                  beat          <= '0;
                  cfg_err       <= (axi_slv_awsize != 3'(WS)) |
                                   ((axi_slv_awburst != BURST_FIXED) && (axi_slv_awburst != BURST_INCR));
                  dec_err       <= 1'b0;
                  lst_err       <= 1'b0;
                  state         <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_hs) begin
                  dec_err <= dec_nxt;
                  lst_err <= lst_nxt;
                  beat    <= beat + LEN_W'(1);
                  if (burst == BURST_INCR) widx <= widx + WIDX_W'(1);
                  // Termination follows the beat count; wlast only feeds the error flag.
                  if (last_beat) begin
                     axi_slv_bvalid <= 1'b1;
                     axi_slv_bresp  <= wr_resp(dec_nxt, cfg_err | lst_nxt);
                     state          <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (axi_slv_bready) begin
                  axi_slv_bvalid <= 1'b0;
                  state          <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   easyaxi_slv_wr_mem #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (mem_we),
      .wr_idx  (widx[IDX_W-1:0]),
      .wr_data (axi_slv_wdata),
      .wr_strb (axi_slv_wstrb),
      .rd_idx  (dbg_raddr),
      .rd_data (dbg_rdata)
   );

endmodule
